// File: rtl/hilo_pkg.sv
// Shared encodings, widths and helpers for the HI/LO register and divide unit.
package hilo_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_STEPS);
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] HILO_OP_MULT_WR = 3'd1;
  localparam logic [OP_W-1:0] HILO_OP_DIV     = 3'd2;
  localparam logic [OP_W-1:0] HILO_OP_DIVU    = 3'd3;
  localparam logic [OP_W-1:0] HILO_OP_MTHI    = 3'd4;
  localparam logic [OP_W-1:0] HILO_OP_MTLO    = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } hilo_state_e;

  // Magnitude of a two's-complement operand; unsigned operands pass through.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                input logic              is_signed);
    return (is_signed && x[DATA_W-1]) ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider datapath: remainder/quotient/divisor registers,
// iteration counter and the trial subtract. Sequencing is owned by the caller.
module div_radix2
  import hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_last_c
);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_div;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;

  // One iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_div});
    w_diff    = w_rem_sh - {1'b0, r_div};
    w_rem_nxt = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    w_quo_nxt = {r_quo[DATA_W-2:0], w_ge};
  end

  // Load operands on start, advance one quotient bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_step) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_quo    = r_quo;
  assign o_rem    = r_rem;
  assign o_last_c = (r_cnt == CNT_W'(DIV_STEPS - 1));

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO architectural register pair with MULT write-back, MTHI/MTLO and an
// iterative 32-bit DIV/DIVU. Optional macro HILO_FWD_EN forwards same-cycle
// single-cycle writes onto hi_o/lo_o.
module hilo_div_unit
  import hilo_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic              flush,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy,
  output logic              div_done
);

  hilo_state_e       r_state;
  hilo_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_busy;
  logic              r_div_done;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_accept;
  logic              w_is_div;
  logic              w_is_signed;
  logic              w_b_zero;
  logic              w_div_start;
  logic              w_step;
  logic [DATA_W-1:0] w_dividend_abs;
  logic [DATA_W-1:0] w_divisor_abs;
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_rem;
  logic              w_last;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  logic              w_hi_we;
  logic              w_lo_we;
  logic [DATA_W-1:0] w_hi_wd;
  logic [DATA_W-1:0] w_lo_wd;
  logic              w_done_nxt;

  // Op decode and acceptance; flush always wins over a new op.
  assign w_accept       = op_valid && !r_busy && !flush;
  assign w_is_div       = (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
  assign w_is_signed    = (op == HILO_OP_DIV);
  assign w_b_zero       = (src_b == '0);
  assign w_div_start    = w_accept && w_is_div && !w_b_zero;
  assign w_step         = (r_state == CALC);
  assign w_dividend_abs = abs_val(src_a, w_is_signed);
  assign w_divisor_abs  = abs_val(src_b, w_is_signed);

  div_radix2 u_div (
    .clk        (clk),
    .rst_n      (resetn),
    .i_start    (w_div_start),
    .i_step     (w_step),
    .i_dividend (w_dividend_abs),
    .i_divisor  (w_divisor_abs),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_last_c   (w_last)
  );

  // Sign fixup: quotient negative when operand signs differ, remainder follows dividend.
  assign w_quo_fix = r_neg_q ? DATA_W'(-w_quo) : w_quo;
  assign w_rem_fix = r_neg_r ? DATA_W'(-w_rem) : w_rem;

  // Next-state and HI/LO write control.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_wd     = r_hi;
    w_lo_wd     = r_lo;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (op)
            HILO_OP_MULT_WR: begin
              w_hi_we = 1'b1;
              w_hi_wd = alu_hi;
              w_lo_we = 1'b1;
              w_lo_wd = alu_lo;
            end
            HILO_OP_MTHI: begin
              w_hi_we = 1'b1;
              w_hi_wd = src_a;
            end
            HILO_OP_MTLO: begin
              w_lo_we = 1'b1;
              w_lo_wd = src_a;
            end
            HILO_OP_DIV, HILO_OP_DIVU: begin
              if (w_b_zero) begin
                w_hi_we    = 1'b1;
                w_hi_wd    = src_a;
                w_lo_we    = 1'b1;
                w_lo_wd    = '1;
                w_done_nxt = 1'b1;
              end else begin
                w_state_nxt = CALC;
              end
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = IDLE;
        if (!flush) begin
          w_hi_we    = 1'b1;
          w_hi_wd    = w_rem_fix;
          w_lo_we    = 1'b1;
          w_lo_wd    = w_quo_fix;
          w_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, busy/done flags and latched sign flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_div_done <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_div_done <= w_done_nxt;
      if (w_div_start) begin
        r_neg_q <= w_is_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
        r_neg_r <= w_is_signed && src_a[DATA_W-1];
      end
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_wd;
      if (w_lo_we) r_lo <= w_lo_wd;
    end
  end

`ifdef HILO_FWD_EN
  // Bypass accepted single-cycle writes; divide results are never forwarded.
  always_comb begin
    hi_o = r_hi;
    lo_o = r_lo;
    if (w_accept) begin
      case (op)
        HILO_OP_MULT_WR: begin
          hi_o = alu_hi;
          lo_o = alu_lo;
        end
        HILO_OP_MTHI: hi_o = src_a;
        HILO_OP_MTLO: lo_o = src_a;
        default: ;
      endcase
    end
  end
`else
  assign hi_o = r_hi;
  assign lo_o = r_lo;
`endif

  assign busy     = r_busy;
  assign div_done = r_div_done;

endmodule
